// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds opcode/funct constants, the FSM state encoding, the instruction
// class produced by the decoder and the datapath select codes driven by
// the controller. No ports; imported by mc_decode and mc_controller.
package mc_ctrl_pkg;

    // Opcode field values (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct field values for R-type (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Next-PC source select
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    // Register-file write address select
    localparam logic [1:0] WREG_RT  = 2'b00;
    localparam logic [1:0] WREG_RD  = 2'b01;
    localparam logic [1:0] WREG_RA  = 2'b10;

    // Register-file write data select
    localparam logic [1:0] WDATA_ALU = 2'b00;
    localparam logic [1:0] WDATA_DM  = 2'b01;
    localparam logic [1:0] WDATA_PC4 = 2'b10;

    // ALU operation codes
    localparam logic [2:0] ALU_FUNCT = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL = 4'd0,
        CL_RALU    = 4'd1,
        CL_JR      = 4'd2,
        CL_ORI     = 4'd3,
        CL_LUI     = 4'd4,
        CL_LW      = 4'd5,
        CL_SW      = 4'd6,
        CL_BEQ     = 4'd7,
        CL_JAL     = 4'd8,
        CL_J       = 4'd9
    } iclass_t;

    // States that wait on mem_ready (and therefore count wait cycles)
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder for the multi-cycle controller.
// Purely combinational: maps opcode/funct to an instruction class and a
// legal flag. Unsupported opcodes, or R-type with an unsupported funct,
// report CL_ILLEGAL with o_legal low.
// Ports:
//   i_opcode  in  6  IR[31:26]
//   i_funct   in  6  IR[5:0]
//   o_class   out    decoded instruction class
//   o_legal   out 1  instruction is supported
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic       o_legal
);

    // Opcode/funct classification
    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_class = CL_RALU;
                    FN_SUBU: o_class = CL_RALU;
                    FN_JR:   o_class = CL_JR;
                    default: o_class = CL_ILLEGAL;
                endcase
            end
            OP_ORI:  o_class = CL_ORI;
            OP_LUI:  o_class = CL_LUI;
            OP_LW:   o_class = CL_LW;
            OP_SW:   o_class = CL_SW;
            OP_BEQ:  o_class = CL_BEQ;
            OP_JAL:  o_class = CL_JAL;
            OP_J:    o_class = CL_J;
            default: o_class = CL_ILLEGAL;
        endcase
        o_legal = (o_class != CL_ILLEGAL);
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit.
// FSM FETCH -> DECODE -> EXEC -> MEM -> WB with req/ready handshake to
// variable-latency instruction and data memory, a memory-wait timeout and
// optional performance counters (compile-time macro MC_CTRL_PERF_EN; when
// undefined the counters are not built and perf_* read 0).
// Ports:
//   clk, reset (async, active high)
//   opcode, funct, zero, mem_ready            : inputs from datapath/memory
//   imem_req, dm_req, DM_WE                   : memory requests
//   ir_we, pc_we, npc_sel                     : IR/PC load strobes and PC source
//   s_Wreg, s_Wdata, GRF_WE                   : register-file write controls
//   EXT_s, zero_EXT_s, ALU_op                 : ALU operand/operation controls
//   instr_done, illegal, timeout_err          : one-cycle status pulses
//   perf_instr, perf_stall                    : performance counters
// Outputs are decoded from the registered state and forced to 0 while reset
// is high, so an in-flight memory request is dropped immediately.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        imem_req,
    output logic        dm_req,
    output logic        DM_WE,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic [1:0]  s_Wreg,
    output logic [1:0]  s_Wdata,
    output logic        GRF_WE,
    output logic        EXT_s,
    output logic        zero_EXT_s,
    output logic [2:0]  ALU_op,
    output logic        instr_done,
    output logic        illegal,
    output logic        timeout_err,
    output logic [31:0] perf_instr,
    output logic [31:0] perf_stall
);

    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_MAX[WAIT_W-1:0];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    iclass_t           w_class;
    logic              w_legal;
    logic              w_waiting;
    logic              w_timeout;

    logic       w_imem_req, w_dm_req, w_dm_we, w_ir_we, w_pc_we;
    logic [1:0] w_npc_sel, w_s_wreg, w_s_wdata;
    logic       w_grf_we, w_ext_s, w_zero_ext_s;
    logic [2:0] w_alu_op;
    logic       w_done, w_illegal, w_timeout_err;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    // A cycle spent waiting on memory; the limit cycle aborts unless ready arrives
    assign w_waiting = is_wait_state(r_state) && !mem_ready;
    assign w_timeout = w_waiting && (r_wait_cnt == WAIT_LIM);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory-wait counter: counts stalled cycles, clears on any exit from FETCH/MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_state_nxt   = r_state;
        w_imem_req    = 1'b0;
        w_dm_req      = 1'b0;
        w_dm_we       = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_npc_sel     = NPC_PC4;
        w_s_wreg      = WREG_RT;
        w_s_wdata     = WDATA_ALU;
        w_grf_we      = 1'b0;
        w_ext_s       = 1'b0;
        w_zero_ext_s  = 1'b0;
        w_alu_op      = ALU_FUNCT;
        w_done        = 1'b0;
        w_illegal     = 1'b0;
        w_timeout_err = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_imem_req  = 1'b1;
                    w_ir_we     = 1'b1;
                    w_pc_we     = 1'b1;
                    w_npc_sel   = NPC_PC4;
                    w_state_nxt = ST_DECODE;
                end else if (w_timeout) begin
                    // Abort: request withdrawn, fetch restarts next cycle
                    w_timeout_err = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_imem_req  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (!w_legal) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else if (w_class == CL_J) begin
                    w_pc_we     = 1'b1;
                    w_npc_sel   = NPC_JMP;
                    w_done      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else if (w_class == CL_JAL) begin
                    // PC updates now; $31 gets the saved PC+4 in WB
                    w_pc_we     = 1'b1;
                    w_npc_sel   = NPC_JMP;
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (w_class)
                    CL_RALU: begin
                        w_alu_op    = ALU_FUNCT;
                        w_state_nxt = ST_WB;
                    end
                    CL_JR: begin
                        w_pc_we     = 1'b1;
                        w_npc_sel   = NPC_RS;
                        w_done      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    CL_ORI: begin
                        w_alu_op     = ALU_OR;
                        w_ext_s      = 1'b1;
                        w_zero_ext_s = 1'b1;
                        w_state_nxt  = ST_WB;
                    end
                    CL_LUI: begin
                        w_alu_op    = ALU_LUI;
                        w_ext_s     = 1'b1;
                        w_state_nxt = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        w_alu_op    = ALU_ADD;
                        w_ext_s     = 1'b1;
                        w_state_nxt = ST_MEM;
                    end
                    CL_BEQ: begin
                        w_alu_op    = ALU_SUB;
                        w_pc_we     = zero;
                        w_npc_sel   = NPC_BR;
                        w_done      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end
                    default: begin
                        w_state_nxt = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_dm_req = 1'b1;
                    w_dm_we  = (w_class == CL_SW);
                    if (w_class == CL_SW) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_timeout_err = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end else begin
                    w_dm_req    = 1'b1;
                    w_dm_we     = (w_class == CL_SW);
                    w_state_nxt = ST_MEM;
                end
            end
            ST_WB: begin
                w_grf_we    = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_FETCH;
                case (w_class)
                    CL_RALU: begin
                        w_s_wreg  = WREG_RD;
                        w_s_wdata = WDATA_ALU;
                    end
                    CL_LW: begin
                        w_s_wreg  = WREG_RT;
                        w_s_wdata = WDATA_DM;
                    end
                    CL_JAL: begin
                        w_s_wreg  = WREG_RA;
                        w_s_wdata = WDATA_PC4;
                    end
                    default: begin
                        w_s_wreg  = WREG_RT;
                        w_s_wdata = WDATA_ALU;
                    end
                endcase
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Everything is held low while reset is asserted
    assign imem_req    = w_imem_req    & ~reset;
    assign dm_req      = w_dm_req      & ~reset;
    assign DM_WE       = w_dm_we       & ~reset;
    assign ir_we       = w_ir_we       & ~reset;
    assign pc_we       = w_pc_we       & ~reset;
    assign npc_sel     = reset ? 2'b00 : w_npc_sel;
    assign s_Wreg      = reset ? 2'b00 : w_s_wreg;
    assign s_Wdata     = reset ? 2'b00 : w_s_wdata;
    assign GRF_WE      = w_grf_we      & ~reset;
    assign EXT_s       = w_ext_s       & ~reset;
    assign zero_EXT_s  = w_zero_ext_s  & ~reset;
    assign ALU_op      = reset ? 3'b000 : w_alu_op;
    assign instr_done  = w_done        & ~reset;
    assign illegal     = w_illegal     & ~reset;
    assign timeout_err = w_timeout_err & ~reset;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_perf_instr;
    logic [31:0] r_perf_stall;

    // Retired-instruction and memory-stall counters (wrap naturally)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_instr <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            r_perf_instr <= r_perf_instr + {31'd0, w_done};
            r_perf_stall <= r_perf_stall + {31'd0, w_waiting};
        end
    end

    assign perf_instr = r_perf_instr;
    assign perf_stall = r_perf_stall;
`else
    assign perf_instr = 32'd0;
    assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus pushes the expected
// control-output vector for every driven cycle; a monitor pops and compares
// on the falling edge.
module tb_mc_controller;

    typedef struct packed {
        logic       imem;
        logic       dm;
        logic       dmwe;
        logic       irwe;
        logic       pcwe;
        logic [1:0] npc;
        logic [1:0] swr;
        logic [1:0] swd;
        logic       grf;
        logic       ext;
        logic       zext;
        logic [2:0] alu;
        logic       done;
        logic       ill;
        logic       to;
    } outs_t;

    typedef struct {
        outs_t exp;
        string tag;
    } sb_item_t;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        imem_req, dm_req, DM_WE, ir_we, pc_we;
    logic [1:0]  npc_sel, s_Wreg, s_Wdata;
    logic        GRF_WE, EXT_s, zero_EXT_s;
    logic [2:0]  ALU_op;
    logic        instr_done, illegal, timeout_err;
    logic [31:0] perf_instr, perf_stall;

    int       n_checks = 0;
    int       n_pass   = 0;
    string    cur_test = "init";
    sb_item_t sb[$];

    mc_controller #(.WAIT_W(4), .WAIT_MAX(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .imem_req    (imem_req),
        .dm_req      (dm_req),
        .DM_WE       (DM_WE),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .npc_sel     (npc_sel),
        .s_Wreg      (s_Wreg),
        .s_Wdata     (s_Wdata),
        .GRF_WE      (GRF_WE),
        .EXT_s       (EXT_s),
        .zero_EXT_s  (zero_EXT_s),
        .ALU_op      (ALU_op),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .timeout_err (timeout_err),
        .perf_instr  (perf_instr),
        .perf_stall  (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t actual();
        outs_t a;
        a.imem = imem_req;  a.dm = dm_req;   a.dmwe = DM_WE;
        a.irwe = ir_we;     a.pcwe = pc_we;  a.npc = npc_sel;
        a.swr  = s_Wreg;    a.swd = s_Wdata; a.grf = GRF_WE;
        a.ext  = EXT_s;     a.zext = zero_EXT_s; a.alu = ALU_op;
        a.done = instr_done; a.ill = illegal; a.to = timeout_err;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest expected vector
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            outs_t    a;
            it = sb.pop_front();
            a  = actual();
            n_checks++;
            if (a === it.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %b expected %b (imem,dm,dmwe,irwe,pcwe,npc,swr,swd,grf,ext,zext,alu,done,ill,to)",
                         it.tag, a, it.exp);
            end
        end
    end

    // Expected-vector builders for each FSM phase
    function automatic outs_t o_fetch(input logic rdy);
        outs_t e = '0;
        e.imem = 1'b1; e.irwe = rdy; e.pcwe = rdy;
        return e;
    endfunction

    function automatic outs_t o_dec(input logic pcwe, input logic [1:0] npc,
                                    input logic done, input logic ill);
        outs_t e = '0;
        e.pcwe = pcwe; e.npc = npc; e.done = done; e.ill = ill;
        return e;
    endfunction

    function automatic outs_t o_exec(input logic [2:0] alu, input logic ext, input logic zext,
                                     input logic pcwe, input logic [1:0] npc, input logic done);
        outs_t e = '0;
        e.alu = alu; e.ext = ext; e.zext = zext; e.pcwe = pcwe; e.npc = npc; e.done = done;
        return e;
    endfunction

    function automatic outs_t o_mem(input logic dmwe, input logic done);
        outs_t e = '0;
        e.dm = 1'b1; e.dmwe = dmwe; e.done = done;
        return e;
    endfunction

    function automatic outs_t o_wb(input logic [1:0] swr, input logic [1:0] swd);
        outs_t e = '0;
        e.grf = 1'b1; e.swr = swr; e.swd = swd; e.done = 1'b1;
        return e;
    endfunction

    function automatic outs_t o_to();
        outs_t e = '0;
        e.to = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for it
    task automatic cyc(input logic rdy, input logic z, input outs_t e);
        sb_item_t it;
        mem_ready = rdy;
        zero      = z;
        it.exp    = e;
        it.tag    = cur_test;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input string name, input logic [5:0] op, input logic [5:0] fn);
        cur_test = name;
        opcode   = op;
        funct    = fn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {12'd0, actual()}, 32'd0);
        chk("reset_perf_instr", perf_instr, 32'd0);
        chk("reset_perf_stall", perf_stall, 32'd0);
        reset = 1'b0;

        // ori: 4 cycles, retires in WB
        set_instr("ori", 6'b001101, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b011, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
        cyc(1'b1, 1'b0, o_wb(2'b00, 2'b00));

        // lw with 3 stall cycles in MEM
        set_instr("lw", 6'b100011, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        repeat (3) cyc(1'b0, 1'b0, o_mem(1'b0, 1'b0));
        cyc(1'b1, 1'b0, o_mem(1'b0, 1'b0));
        cyc(1'b1, 1'b0, o_wb(2'b00, 2'b01));
        chk("lw_perf_stall", perf_stall, PERF ? 32'd3 : 32'd0);

        // beq taken / not taken
        set_instr("beq_taken", 6'b000100, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, o_exec(3'b010, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1));
        set_instr("beq_not_taken", 6'b000100, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b010, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1));

        // jal, then j
        set_instr("jal", 6'b000011, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, o_dec(1'b1, 2'b10, 1'b0, 1'b0));
        cyc(1'b1, 1'b0, o_wb(2'b10, 2'b10));
        set_instr("j", 6'b000010, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, o_dec(1'b1, 2'b10, 1'b1, 1'b0));

        // sw, addu, jr, lui
        set_instr("sw", 6'b101011, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc(1'b1, 1'b0, o_mem(1'b1, 1'b1));
        set_instr("addu", 6'b000000, 6'b100001);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc(1'b1, 1'b0, o_wb(2'b01, 2'b00));
        set_instr("jr", 6'b000000, 6'b001000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1));
        set_instr("lui", 6'b001111, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b100, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc(1'b1, 1'b0, o_wb(2'b00, 2'b00));
        chk("perf_instr_10", perf_instr, PERF ? 32'd10 : 32'd0);

        // illegal opcode and illegal R-type funct
        set_instr("illegal_op", 6'b111111, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, o_dec(1'b0, 2'b00, 1'b0, 1'b1));
        set_instr("illegal_funct", 6'b000000, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, o_dec(1'b0, 2'b00, 1'b0, 1'b1));

        // FETCH timeout on the 16th wait cycle, then fetch restarts
        cur_test = "fetch_timeout";
        repeat (15) cyc(1'b0, 1'b0, o_fetch(1'b0));
        cyc(1'b0, 1'b0, o_to());
        // ready on the limit cycle wins over the timeout
        cur_test = "fetch_ready_at_limit";
        repeat (15) cyc(1'b0, 1'b0, o_fetch(1'b0));
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, o_dec(1'b0, 2'b00, 1'b0, 1'b1));

        // MEM timeout on sw
        set_instr("mem_timeout", 6'b101011, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        repeat (15) cyc(1'b0, 1'b0, o_mem(1'b1, 1'b0));
        cyc(1'b0, 1'b0, o_to());
        cur_test = "after_mem_timeout";
        cyc(1'b0, 1'b0, o_fetch(1'b0));
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc(1'b1, 1'b0, o_mem(1'b1, 1'b1));
        chk("perf_instr_11", perf_instr, PERF ? 32'd11 : 32'd0);

        // Reset in the middle of a lw MEM wait
        set_instr("reset_mid_mem", 6'b100011, 6'b000000);
        cyc(1'b1, 1'b0, o_fetch(1'b1));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, o_exec(3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
        cyc(1'b0, 1'b0, o_mem(1'b0, 1'b0));
        reset = 1'b1;
        #1;
        chk("reset_mid_mem_outs", {12'd0, actual()}, 32'd0);
        chk("reset_mid_mem_perf", perf_instr, 32'd0);
        @(posedge clk);
        #2;
        chk("reset_hold_outs", {12'd0, actual()}, 32'd0);
        reset = 1'b0;
        cur_test = "after_reset_fetch";
        cyc(1'b0, 1'b0, o_fetch(1'b0));
        cyc(1'b1, 1'b0, o_fetch(1'b1));

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
